gd_step_4d: RTL
===============

# gd_step_4d

Iteration engine for the 4D fixed-point gradient-descent datapath. It holds the current point x (four Q24.8 coordinates) and requests a gradient from the upstream gradient unit. It applies x_new = x − lr·grad one coordinate per cycle, and presents each (x_old, x_new) pair to the external convergence comparator (±0.0625 window). It terminates when all four coordinates converge in the same iteration, or when MAX_ITER is reached.

## Interface
- MAX_ITER, 1024: iteration limit, 1..65535
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  pulse; samples x_init and lr; honoured only in IDLE
- x_init  in  128  initial point, coord i at [32i+31:32i], signed Q24.8
- lr  in  32  learning rate, signed Q24.8
- grad_req  out  1  high while waiting for a gradient at x_out
- x_out  out  128  current point, same packing as x_init
- grad_valid  in  1  gradient present; accepted only while grad_req=1
- grad  in  128  gradient at x_out, same packing
- conv_a  out  32  x_old of coordinate under update (comparator operand A)
- conv_b  out  32  x_new of same coordinate (comparator operand B)
- conv_in  in  1  comparator result for conv_a/conv_b, combinational, same cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on termination
- converged  out  1  result of last run; held until next start
- iter_count  out  16  completed iterations of current/last run

## Operation
- States: IDLE, REQ, UPD, CHECK, DONE.
- IDLE: start=1 → latch x_init into x, lr into lr_r, iter_count←0, converged←0 → REQ.
- REQ: grad_req=1. grad_valid=1 → capture grad into grad_r, idx←0, all_conv←1 → UPD. Otherwise remain in REQ indefinitely.
- UPD (4 cycles, idx 0..3):
  - conv_a=x[idx], conv_b=x_new[idx].
  - all_conv←all_conv & conv_in; x[idx]←x_new[idx].
  - idx=3 → CHECK.
- CHECK: iter_count+1. If all_conv=1 → converged←1, go to DONE. Else if incremented count = MAX_ITER → converged←0, go to DONE. Else → REQ.
- DONE: done=1 for one cycle → IDLE.
- Arithmetic per coordinate:
  - p = lr_r × grad_r[idx], full 64-bit signed.
  - step = p >>> 8 (arithmetic), saturated to [0x8000_0000, 0x7FFF_FFFF].
  - x_new = x[idx] − step, computed in 33 bits, saturated to the same range.
- Outside UPD: conv_a=conv_b=0 and conv_in is ignored.
- start while busy, or grad_valid outside REQ: ignored, no side effect.

## Timing
- Reset values: x=0, x_out=0, grad_req=0, conv_a=conv_b=0, busy=0, done=0, converged=0, iter_count=0, state=IDLE.
- start at edge N → busy and grad_req high after N.
- Grad accepted at edge M → UPD idx0..3 at cycles M+1..M+4, CHECK at M+5.
- Next grad_req is high from M+6, or done pulses in cycle M+6.
- Minimum iteration: 6 cycles with zero-latency gradient.
- x_out updates one coordinate per UPD edge. The upstream unit must sample x_out only while grad_req=1, when x_out is stable.
- iter_count becomes valid the cycle after CHECK. converged is valid in the done cycle and is held afterwards.
- Reset asserted mid-run (any state): all registers return to reset values immediately; no done pulse.
- start in the DONE cycle: ignored. start is accepted from the following IDLE cycle onward.

## Structure
- Package gd_pkg contains:
  - Q24.8 constants: FRAC_BITS=8, Q_MAX=32'h7FFF_FFFF, Q_MIN=32'h8000_0000, Q_ONE=32'h0000_0100.
  - State enum gd_state_t.
  - Coordinate count NDIM=4.
  - Saturating-narrow function.
- One combinational sub-module, gd_step_sat: inputs x, lr, g (32-bit each), output x_new. Implements the multiply, shift and subtract with saturation.
- The convergence comparator is external, wired via conv_a/conv_b/conv_in.

## Test plan
- Reset: hold rst_n=0 then release → all outputs 0, busy=0. Pulse grad_valid with no start → no change.
- Quadratic bowl, grad=2x, x_init all 0x100, lr=0x80:
  - Iteration 1: x→0, not converged.
  - Iteration 2: no change, converged.
  - done with converged=1, iter_count=2, x_out=0.
- Non-convergence: MAX_ITER=3, constant grad 0x100 per coordinate, lr=0x100, x_init 0x500 → done with converged=0, iter_count=3, each coordinate 0x200.
- Saturation: coord0 x=0x8000_0100, lr=0x100, grad0=0x7FFF_FF00 → x[0]=0x8000_0000. Also check the step clamp with lr=0x7FFF_FFFF, grad=0x7FFF_FFFF.
- Handshake stall: grad_valid low for 20 cycles → grad_req held, x_out stable, no UPD. Also check that start pulsed mid-run and grad_valid during UPD are both ignored.
- Reset mid-run: assert rst_n=0 during UPD idx=2 → all outputs 0 asynchronously, no done. A subsequent start runs cleanly from x_init.

Source files
------------

// File: rtl/gd_pkg.sv
// Shared definitions for the 4D gradient-descent iteration engine:
// Q24.8 constants, FSM state type and the saturating narrow helper.
package gd_pkg;

  localparam int          FRAC_BITS = 8;
  localparam logic [31:0] Q_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN     = 32'h8000_0000;
  localparam logic [31:0] Q_ONE     = 32'h0000_0100;
  localparam int          NDIM      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_UPD,
    ST_CHECK,
    ST_DONE
  } gd_state_t;

  // Clamp a wide signed value into the signed Q24.8 range.
  function automatic logic [31:0] sat_narrow(input logic signed [63:0] v);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = $signed({{32{1'b0}}, Q_MAX});
    lo = $signed({{32{1'b1}}, Q_MIN});
    if (v > hi)      return Q_MAX;
    else if (v < lo) return Q_MIN;
    else             return v[31:0];
  endfunction

endpackage

// File: rtl/gd_step_sat.sv
// One coordinate of the descent step: x_new = x - sat(lr*g >>> 8), saturated.
// Purely combinational.
module gd_step_sat
  import gd_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] lr,
  input  logic [31:0] g,
  output logic [31:0] x_new
);

  logic signed [63:0] w_p;
  logic signed [63:0] w_sh;
  logic        [31:0] w_step;
  logic signed [32:0] w_diff;

  // Full-precision product, then drop the extra fraction bits arithmetically.
  assign w_p    = $signed(lr) * $signed(g);
  assign w_sh   = w_p >>> FRAC_BITS;
  assign w_step = sat_narrow(w_sh);

  // 33-bit subtract cannot overflow; clamp back into Q24.8.
  assign w_diff = $signed({x[31], x}) - $signed({w_step[31], w_step});
  assign x_new  = sat_narrow({{31{w_diff[32]}}, w_diff});

endmodule

// File: rtl/gd_step_4d.sv
// Iteration engine: holds the point x, requests gradients, updates one
// coordinate per cycle through the external convergence comparator and
// stops on joint convergence or after MAX_ITER iterations.
module gd_step_4d
  import gd_pkg::*;
#(
  parameter int MAX_ITER = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] x_init,
  input  logic [31:0]  lr,
  output logic         grad_req,
  output logic [127:0] x_out,
  input  logic         grad_valid,
  input  logic [127:0] grad,
  output logic [31:0]  conv_a,
  output logic [31:0]  conv_b,
  input  logic         conv_in,
  output logic         busy,
  output logic         done,
  output logic         converged,
  output logic [15:0]  iter_count
);

  gd_state_t                r_state;
  gd_state_t                w_next;
  logic [NDIM-1:0][31:0]    r_x;
  logic [NDIM-1:0][31:0]    r_grad;
  logic [NDIM-1:0][31:0]    w_x_new;
  logic [31:0]              r_lr;
  logic [1:0]               r_idx;
  logic                     r_all_conv;
  logic [15:0]              r_iter;
  logic                     r_conv;
  logic [16:0]              w_iter_inc;
  logic                     w_at_limit;

  // Every lane evaluates its step each cycle; the FSM picks the one under update.
  for (genvar gi = 0; gi < NDIM; gi++) begin : g_lane
    gd_step_sat u_step (
      .x     (r_x[gi]),
      .lr    (r_lr),
      .g     (r_grad[gi]),
      .x_new (w_x_new[gi])
    );
  end

  assign w_iter_inc = {1'b0, r_iter} + 17'd1;
  assign w_at_limit = (w_iter_inc == 17'(MAX_ITER));

  assign x_out      = r_x;
  assign iter_count = r_iter;
  assign converged  = r_conv;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and Moore-style outputs; comparator operands only driven in UPD.
  always_comb begin
    w_next   = r_state;
    grad_req = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    conv_a   = '0;
    conv_b   = '0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_REQ;
      end
      ST_REQ: begin
        grad_req = 1'b1;
        if (grad_valid) w_next = ST_UPD;
      end
      ST_UPD: begin
        conv_a = r_x[r_idx];
        conv_b = w_x_new[r_idx];
        if (r_idx == 2'd3) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_all_conv || w_at_limit) w_next = ST_DONE;
        else                          w_next = ST_REQ;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath registers: point, operands, coordinate index and run results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_grad     <= '0;
      r_lr       <= '0;
      r_idx      <= '0;
      r_all_conv <= 1'b0;
      r_iter     <= '0;
      r_conv     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          r_x    <= x_init;
          r_lr   <= lr;
          r_iter <= '0;
          r_conv <= 1'b0;
        end
        ST_REQ: if (grad_valid) begin
          r_grad     <= grad;
          r_idx      <= '0;
          r_all_conv <= 1'b1;
        end
        ST_UPD: begin
          r_x[r_idx] <= w_x_new[r_idx];
          r_all_conv <= r_all_conv & conv_in;
          r_idx      <= r_idx + 2'd1;
        end
        ST_CHECK: begin
          r_iter <= w_iter_inc[15:0];
          r_conv <= r_all_conv;
        end
        default: ;
      endcase
    end
  end

endmodule
